ahb_bus_protocol_bridge: RTL and testbench

AHB-Lite subordinate that converts AHB address/data-phase transfers into single-beat requests on the initiator (protocol) side of bus_protocol_if. It sits between the SoC AHB fabric and register-mapped peripherals such as AHBuart, which consume the peripheral side of the same interface. The bridge handles wait states driven by `request_stall` and two-cycle AHB ERROR responses. It also derives byte strobes from HSIZE/HADDR.

---
 rtl/ahb_bus_protocol_bridge_if.sv | 30 +++
 rtl/ahb_bus_protocol_bridge.sv | 128 ++++++++++++
 tb/tb_ahb_bus_protocol_bridge.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bus_protocol_bridge_if.sv
// Single-beat register bus shared by the AHB bridge (protocol side) and peripherals.
interface bus_protocol_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                  wen;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     strobe;
  logic                  is_burst;
  logic [1:0]            burst_type;
  logic [3:0]            burst_length;
  logic                  secure_transfer;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  error;
  logic                  request_stall;

  modport protocol (
    output wen, ren, addr, wdata, strobe, is_burst, burst_type, burst_length, secure_transfer,
    input  rdata, error, request_stall
  );

  modport peripheral (
    input  wen, ren, addr, wdata, strobe, is_burst, burst_type, burst_length, secure_transfer,
    output rdata, error, request_stall
  );
endinterface

// File: rtl/ahb_bus_protocol_bridge.sv
// AHB-Lite subordinate turning address/data-phase transfers into single-beat
// bus_protocol_if requests, with stall-driven wait states and two-cycle ERROR.
module ahb_bus_protocol_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  bus_protocol_if.protocol      bp
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [STRB_W-1:0]     strobe_q, strobe_d;

  logic                  accept_c;
  logic                  bad_c;
  logic [STRB_W-1:0]     strobe_c;
  logic                  unused_htrans_c;

  assign unused_htrans_c = HTRANS[0];

  // Address-phase decode: BUSY/IDLE (HTRANS[1]=0) never start a transfer.
  always_comb begin
    accept_c = HSEL && HREADY && HTRANS[1];
    bad_c    = (HSIZE > 3'd2)
            || ((HSIZE == 3'd1) && HADDR[0])
            || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    strobe_c = '0;
    case (HSIZE)
      3'd0:    strobe_c = STRB_W'(STRB_W'(1) << HADDR[1:0]);
      3'd1:    strobe_c = STRB_W'(STRB_W'(3) << {HADDR[1], 1'b0});
      3'd2:    strobe_c = {STRB_W{1'b1}};
      default: strobe_c = '0;
    endcase
  end

  // Next state and data-phase response; wen/ren decode straight from state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    strobe_d  = strobe_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    bp.wen    = 1'b0;
    bp.ren    = 1'b0;

    case (state_q)
      ST_ACCESS: begin
        bp.wen = write_q;
        bp.ren = !write_q;
        if (bp.request_stall) begin
          HREADYOUT = 1'b0;
        end else if (bp.error) begin
          HRESP     = 1'b1;
          HREADYOUT = 1'b0;
          state_d   = ST_ERR2;
        end else begin
          if (!write_q) HRDATA = bp.rdata;
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP   = 1'b1;
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    // A new address phase only lands in a cycle where we are ready.
    if (accept_c && HREADYOUT) begin
      addr_d   = HADDR;
      write_d  = HWRITE;
      strobe_d = bad_c ? '0 : strobe_c;
      state_d  = bad_c ? ST_ERR1 : ST_ACCESS;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      strobe_q <= strobe_d;
    end
  end

  assign bp.addr            = addr_q;
  assign bp.strobe          = strobe_q;
  assign bp.wdata           = HWDATA;
  assign bp.is_burst        = 1'b0;
  assign bp.burst_type      = 2'd0;
  assign bp.burst_length    = 4'd0;
  assign bp.secure_transfer = 1'b0;

endmodule

// File: tb/tb_ahb_bus_protocol_bridge.sv
// Scoreboard bench for ahb_bus_protocol_bridge: directed AHB sequences, a
// peripheral responder, and AHB/bp monitors popping expected-result queues.
module tb_ahb_bus_protocol_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          nReset;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [DW-1:0] HRDATA;

  bus_protocol_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bp_if ();

  ahb_bus_protocol_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .bp        (bp_if)
  );

  // Single subordinate on the fabric: HREADY mirrors our HREADYOUT.
  assign HREADY = HREADYOUT;

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
  } cpl_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          stall;
    logic        err;
    logic [31:0] rdata;
  } cfg_t;

  stim_t stim_q[$];
  cpl_t  cpl_q[$];
  req_t  req_q[$];
  cfg_t  cfg_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue one NONSEQ transfer with its hand-computed bp request and AHB response.
  task automatic xfer(input logic write, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [3:0] strobe, input bit good,
                      input int stall, input logic perr, input logic [31:0] rdata);
    stim_q.push_back('{1'b1, 2'b10, write, addr, size, wdata});
    if (good) begin
      req_q.push_back('{write, addr, strobe, wdata});
      cfg_q.push_back('{stall, perr, rdata});
      cpl_q.push_back('{perr, (write || perr) ? 32'h0 : rdata, stall + (perr ? 1 : 0)});
    end else begin
      cpl_q.push_back('{1'b1, 32'h0, 1});
    end
  endtask

  task automatic noise(input logic sel, input logic [1:0] trans);
    stim_q.push_back('{sel, trans, 1'b1, 32'h0000_1000, 3'd2, 32'h0});
  endtask

  task automatic wait_ready();
    int   n;
    logic ok;
    n = 0;
    do begin
      @(negedge clk);
      ok = HREADY;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL hready_timeout: HREADY stuck at %0b, expected 1 within 100 cycles", HREADY);
    end
  endtask

  // Drive queued address phases, holding HWDATA for the pending data phase.
  task automatic run_seq();
    stim_t       s;
    logic [31:0] prev_wdata;
    prev_wdata = 32'h0;
    while (stim_q.size() > 0) begin
      s      = stim_q.pop_front();
      HSEL   = s.sel;
      HTRANS = s.trans;
      HADDR  = s.addr;
      HWRITE = s.write;
      HSIZE  = s.size;
      HWDATA = prev_wdata;
      if (s.sel && s.trans[1]) begin
        wait_ready();
        prev_wdata = s.wdata;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = 32'h0;
    HWDATA = prev_wdata;
    wait_ready();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Peripheral responder: per-request stall count, error flag and read data.
  cfg_t cfg_cur;
  bit   busy;
  int   stall_left;
  initial begin
    bp_if.request_stall = 1'b0;
    bp_if.error         = 1'b0;
    bp_if.rdata         = 32'hDEAD_BEEF;
    busy                = 1'b0;
    stall_left          = 0;
    cfg_cur             = '{0, 1'b0, 32'h0};
    forever begin
      @(posedge clk);
      #1;
      if (!nReset) begin
        busy                = 1'b0;
        stall_left          = 0;
        bp_if.request_stall = 1'b0;
        bp_if.error         = 1'b0;
        bp_if.rdata         = 32'hDEAD_BEEF;
      end else if (bp_if.wen || bp_if.ren) begin
        if (!busy) begin
          if (cfg_q.size() > 0) cfg_cur = cfg_q.pop_front();
          else                  cfg_cur = '{0, 1'b0, 32'h0};
          stall_left = cfg_cur.stall;
          busy       = 1'b1;
        end
        bp_if.rdata = cfg_cur.rdata;
        if (stall_left > 0) begin
          bp_if.request_stall = 1'b1;
          bp_if.error         = 1'b0;
          stall_left--;
        end else begin
          bp_if.request_stall = 1'b0;
          bp_if.error         = cfg_cur.err;
          busy                = 1'b0;
        end
      end else begin
        bp_if.request_stall = 1'b0;
        bp_if.error         = 1'b0;
        bp_if.rdata         = 32'hDEAD_BEEF;
      end
    end
  end

  // AHB monitor: track data phases, count wait states, compare completions.
  cpl_t cur_cpl;
  bit   dp = 1'b0;
  int   waits = 0;
  always @(negedge clk) begin
    if (!nReset) begin
      dp = 1'b0;
    end else begin
      if (dp) begin
        if (!HREADYOUT) begin
          waits++;
          check("hresp_wait", 64'(HRESP), 64'(cur_cpl.resp));
        end else begin
          check("hresp_done", 64'(HRESP), 64'(cur_cpl.resp));
          check("hrdata", 64'(HRDATA), 64'(cur_cpl.rdata));
          check("wait_states", 64'(waits), 64'(cur_cpl.waits));
          dp = 1'b0;
        end
      end else begin
        check("idle_bus", 64'({HREADYOUT, HRESP, HRDATA, bp_if.wen, bp_if.ren}),
              64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
      end
      if (HSEL && HREADY && HTRANS[1]) begin
        if (cpl_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ahb_accept: got accepted transfer at 0x%0h, expected none queued", HADDR);
          dp = 1'b0;
        end else begin
          cur_cpl = cpl_q.pop_front();
          dp      = 1'b1;
          waits   = 0;
        end
      end
    end
  end

  // bp monitor: every request cycle matches the head request; pop when consumed.
  req_t cur_req;
  always @(negedge clk) begin
    if (nReset && (bp_if.wen || bp_if.ren)) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bp_request: got wen=%0b ren=%0b addr=0x%0h, expected no request",
                 bp_if.wen, bp_if.ren, bp_if.addr);
      end else begin
        cur_req = req_q[0];
        check("bp_dir", 64'({bp_if.wen, bp_if.ren}), 64'({cur_req.write, !cur_req.write}));
        check("bp_addr", 64'(bp_if.addr), 64'(cur_req.addr));
        check("bp_strobe", 64'(bp_if.strobe), 64'(cur_req.strobe));
        check("bp_hints", 64'({bp_if.is_burst, bp_if.burst_type, bp_if.burst_length,
                               bp_if.secure_transfer}), 64'(0));
        if (cur_req.write) check("bp_wdata", 64'(bp_if.wdata), 64'(cur_req.wdata));
        if (!bp_if.request_stall) void'(req_q.pop_front());
      end
    end
  end

  initial begin
    nReset = 1'b0;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = 32'h0;
    HWRITE = 1'b0;
    HSIZE  = 3'd0;
    HWDATA = 32'h0;
    #3;
    check("rst_hreadyout", 64'(HREADYOUT), 64'(1));
    check("rst_hresp", 64'(HRESP), 64'(0));
    check("rst_hrdata", 64'(HRDATA), 64'(0));
    check("rst_wen_ren", 64'({bp_if.wen, bp_if.ren}), 64'(0));
    check("rst_addr", 64'(bp_if.addr), 64'(0));
    check("rst_strobe", 64'(bp_if.strobe), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    @(posedge clk);
    #1;

    // Word write, no stall.
    xfer(1'b1, 32'h18, 3'd2, 32'h0000_000F, 4'hF, 1, 0, 1'b0, 32'h1234_5678);
    run_seq();

    // Byte read at 0x1D with three stall cycles.
    xfer(1'b0, 32'h1D, 3'd0, 32'h0, 4'b0010, 1, 3, 1'b0, 32'hAABB_CCDD);
    run_seq();

    // Back-to-back write then read.
    xfer(1'b1, 32'h00, 3'd2, 32'h1122_3344, 4'hF, 1, 0, 1'b0, 32'h0BAD_0BAD);
    xfer(1'b0, 32'h04, 3'd2, 32'h0, 4'hF, 1, 0, 1'b0, 32'h5566_7788);
    run_seq();

    // Misaligned word read.
    xfer(1'b0, 32'h02, 3'd2, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0);
    run_seq();

    // Peripheral error, next NONSEQ lands in the second ERROR cycle.
    xfer(1'b1, 32'h20, 3'd2, 32'hDEAD_C0DE, 4'hF, 1, 0, 1'b1, 32'h0);
    xfer(1'b0, 32'h24, 3'd2, 32'h0, 4'hF, 1, 0, 1'b0, 32'hCAFE_F00D);
    run_seq();

    // Mixed sizes, ignored BUSY/unselected cycles, chained size errors.
    xfer(1'b1, 32'h06, 3'd1, 32'hAAAA_0000, 4'b1100, 1, 0, 1'b0, 32'h0);
    noise(1'b1, 2'b01);
    noise(1'b0, 2'b10);
    xfer(1'b1, 32'h03, 3'd0, 32'h7700_0000, 4'b1000, 1, 0, 1'b0, 32'h0);
    xfer(1'b0, 32'h01, 3'd1, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0);
    xfer(1'b1, 32'h00, 3'd3, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0);
    xfer(1'b0, 32'h00, 3'd0, 32'h0, 4'b0001, 1, 1, 1'b0, 32'h0000_00EE);
    xfer(1'b0, 32'h0E, 3'd1, 32'h0, 4'b1100, 1, 0, 1'b0, 32'hBEEF_0000);
    run_seq();

    // Asynchronous reset while a write is stalled in ACCESS.
    req_q.push_back('{1'b1, 32'h40, 4'hF, 32'h5A5A_5A5A});
    cfg_q.push_back('{5, 1'b0, 32'h0});
    cpl_q.push_back('{1'b0, 32'h0, 5});
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = 32'h40;
    HWRITE = 1'b1;
    HSIZE  = 3'd2;
    wait_ready();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWDATA = 32'h5A5A_5A5A;
    @(posedge clk);
    #3;
    check("pre_rst_wen", 64'({bp_if.wen, HREADYOUT}), 64'({1'b1, 1'b0}));
    nReset = 1'b0;
    #1;
    check("async_rst_wen_ren", 64'({bp_if.wen, bp_if.ren}), 64'(0));
    check("async_rst_hready", 64'({HREADYOUT, HRESP, HRDATA}), 64'({1'b1, 1'b0, 32'h0}));
    repeat (2) @(posedge clk);
    #1;
    req_q.delete();
    cfg_q.delete();
    cpl_q.delete();
    nReset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 64'({bp_if.wen, bp_if.ren, HREADYOUT, HRESP}), 64'(4'b0010));
    xfer(1'b0, 32'h44, 3'd2, 32'h0, 4'hF, 1, 0, 1'b0, 32'h1357_9BDF);
    run_seq();

    check("cpl_q_drained", 64'(cpl_q.size()), 64'(0));
    check("req_q_drained", 64'(req_q.size()), 64'(0));
    check("cfg_q_drained", 64'(cfg_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
